// File: rtl/ac_pkg.sv
// Shared Aho-Corasick matcher types: widths, special states,
// lookup FSM encoding and the goto-table row record.
package ac_pkg;

  localparam int STATE_W = 8;
  localparam int CHAR_W  = 4;

  localparam logic [STATE_W-1:0] ROOT_STATE = '0;
  localparam logic [STATE_W-1:0] END_MARK   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } ac_fsm_e;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [CHAR_W-1:0]  chara;
    logic [STATE_W-1:0] next;
  } goto_row_t;

endpackage

// File: rtl/goto_row_match.sv
// Compares one goto-table row against the latched request and
// flags the end-of-table marker.
module goto_row_match
  import ac_pkg::*;
(
  input  logic [STATE_W-1:0] row_state,
  input  logic [CHAR_W-1:0]  row_chara,
  input  logic [STATE_W-1:0] req_state,
  input  logic [CHAR_W-1:0]  req_chara,
  output logic               match,
  output logic               end_mark
);

  assign match    = (row_state == req_state) &&
                    (row_chara == req_chara);
  assign end_mark = (row_state == END_MARK);

endmodule

// File: rtl/goto_lookup_ctrl.sv
// Goto-table RAM sequencer: linear scan from row 0, returns the
// goto next state or a miss for the failure-function stage.
module goto_lookup_ctrl #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 12,
  parameter int STATE_W = ac_pkg::STATE_W,
  parameter int CHAR_W  = ac_pkg::CHAR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [STATE_W-1:0] REQ_STATE,
  input  logic [CHAR_W-1:0]  REQ_CHARA,
  output logic [ADDR_W-1:0]  ADDR_G,
  input  logic [STATE_W-1:0] CURRENT_STATE_G,
  input  logic [CHAR_W-1:0]  CHARA,
  input  logic [STATE_W-1:0] NEXT_STATE,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_HIT,
  output logic [STATE_W-1:0] RSP_NEXT_STATE
);

  import ac_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  ac_fsm_e state_q, state_d;

  logic [STATE_W-1:0] lat_state_q, lat_state_d;
  logic [CHAR_W-1:0]  lat_chara_q, lat_chara_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, row_addr_q;
  logic               rd_pend_q, rd_pend_d;
  logic               ram_vld_q, ram_vld_d;
  logic               row_vld_q, row_vld_d;
  goto_row_t          row_q;

  logic               rsp_valid_d, rsp_hit_d;
  logic [STATE_W-1:0] rsp_next_d;
  logic               match, end_mark, term;

  assign REQ_READY = (state_q == IDLE) && !RST;

  goto_row_match u_match (
    .row_state (row_q.state),
    .row_chara (row_q.chara),
    .req_state (lat_state_q),
    .req_chara (lat_chara_q),
    .match     (match),
    .end_mark  (end_mark)
  );

  // Row data is re-registered once before evaluation; stale reads
  // issued past the terminating row die in the valid pipeline.
  assign term = row_vld_q &&
                (match || end_mark || row_addr_q == LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = ADDR_G;
    lat_state_d = lat_state_q;
    lat_chara_d = lat_chara_q;
    rd_pend_d   = rd_pend_q;
    ram_vld_d   = rd_pend_q;
    row_vld_d   = ram_vld_q;
    rsp_valid_d = RSP_VALID;
    rsp_hit_d   = RSP_HIT;
    rsp_next_d  = RSP_NEXT_STATE;
    unique case (state_q)
      IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          lat_state_d = REQ_STATE;
          lat_chara_d = REQ_CHARA;
          addr_d      = '0;
          rd_pend_d   = 1'b1;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (ADDR_G != LAST) addr_d = ADDR_G + ONE;
        if (term) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rd_pend_d   = 1'b0;
          ram_vld_d   = 1'b0;
          row_vld_d   = 1'b0;
          rsp_hit_d   = match ||
                        (lat_state_q == ROOT_STATE);
          rsp_next_d  = match ? row_q.next : '0;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      ADDR_G         <= '0;
      lat_state_q    <= '0;
      lat_chara_q    <= '0;
      rd_pend_q      <= 1'b0;
      ram_vld_q      <= 1'b0;
      row_vld_q      <= 1'b0;
      rd_addr_q      <= '0;
      row_addr_q     <= '0;
      row_q          <= '0;
      RSP_VALID      <= 1'b0;
      RSP_HIT        <= 1'b0;
      RSP_NEXT_STATE <= '0;
    end else begin
      state_q        <= state_d;
      ADDR_G         <= addr_d;
      lat_state_q    <= lat_state_d;
      lat_chara_q    <= lat_chara_d;
      rd_pend_q      <= rd_pend_d;
      ram_vld_q      <= ram_vld_d;
      row_vld_q      <= row_vld_d;
      rd_addr_q      <= ADDR_G;
      row_addr_q     <= rd_addr_q;
      row_q.state    <= CURRENT_STATE_G;
      row_q.chara    <= CHARA;
      row_q.next     <= NEXT_STATE;
      RSP_VALID      <= rsp_valid_d;
      RSP_HIT        <= rsp_hit_d;
      RSP_NEXT_STATE <= rsp_next_d;
    end
  end

endmodule

// File: tb/tb_goto_lookup_ctrl.sv
// Bench for goto_lookup_ctrl: table-driven RAM model plus a
// first-principles scan model for latency, hit and next state.
module tb_goto_lookup_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [7:0]  REQ_STATE;
  logic [3:0]  REQ_CHARA;
  logic [11:0] ADDR_G;
  logic [7:0]  CURRENT_STATE_G;
  logic [3:0]  CHARA;
  logic [7:0]  NEXT_STATE;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic        RSP_HIT;
  logic [7:0]  RSP_NEXT_STATE;

  int errors = 0;
  int checks = 0;
  int addr_over = 0;

  logic [7:0] tbl_s [32];
  logic [3:0] tbl_c [32];
  logic [7:0] tbl_n [32];

  always #5 CLK = ~CLK;

  goto_lookup_ctrl dut (
    .CLK             (CLK),
    .RST             (RST),
    .REQ_VALID       (REQ_VALID),
    .REQ_READY       (REQ_READY),
    .REQ_STATE       (REQ_STATE),
    .REQ_CHARA       (REQ_CHARA),
    .ADDR_G          (ADDR_G),
    .CURRENT_STATE_G (CURRENT_STATE_G),
    .CHARA           (CHARA),
    .NEXT_STATE      (NEXT_STATE),
    .RSP_VALID       (RSP_VALID),
    .RSP_READY       (RSP_READY),
    .RSP_HIT         (RSP_HIT),
    .RSP_NEXT_STATE  (RSP_NEXT_STATE)
  );

  // synchronous-read goto RAM
  always @(posedge CLK) begin
    CURRENT_STATE_G <= tbl_s[ADDR_G[4:0]];
    CHARA           <= tbl_c[ADDR_G[4:0]];
    NEXT_STATE      <= tbl_n[ADDR_G[4:0]];
  end

  always @(negedge CLK)
    if (ADDR_G > 12'd31) addr_over++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Scan the table in order: first matching row wins, a 0xFF
  // source state ends the table, row 31 is the last one.
  task automatic ref_lookup(input logic [7:0] st,
                            input logic [3:0] ch,
                            output int k,
                            output bit hit,
                            output logic [7:0] nx);
    k = 31;
    hit = (st == 8'h00);
    nx = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (tbl_s[i] == st && tbl_c[i] == ch) begin
        k = i; hit = 1'b1; nx = tbl_n[i];
        break;
      end
      if (tbl_s[i] == 8'hFF) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_req(input logic [7:0] st,
                        input logic [3:0] ch,
                        input int bp,
                        input bit hold);
    int k, cyc, ea;
    bit eh;
    logic [7:0] en;
    ref_lookup(st, ch, k, eh, en);
    @(negedge CLK);
    REQ_STATE = st;
    REQ_CHARA = ch;
    REQ_VALID = 1'b1;
    chk("req_ready_idle", 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    if (!hold) REQ_VALID = 1'b0;
    cyc = 0;
    chk("addr_seq", 32'(ADDR_G), 32'd0);
    while (!RSP_VALID && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
      ea = (cyc > 31) ? 31 : cyc;
      chk("addr_seq", 32'(ADDR_G), 32'(ea));
    end
    chk("latency", 32'(cyc), 32'(k + 3));
    chk("rsp_hit", 32'(RSP_HIT), 32'(eh));
    chk("rsp_next", 32'(RSP_NEXT_STATE), 32'(en));
    ea = (k + 3 > 31) ? 31 : k + 3;
    repeat (bp) begin
      @(posedge CLK); #1;
      chk("bp_valid", 32'(RSP_VALID), 32'd1);
      chk("bp_hit", 32'(RSP_HIT), 32'(eh));
      chk("bp_next", 32'(RSP_NEXT_STATE), 32'(en));
      chk("bp_req_ready", 32'(REQ_READY), 32'd0);
      chk("bp_addr_hold", 32'(ADDR_G), 32'(ea));
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    chk("rsp_valid_clr", 32'(RSP_VALID), 32'd0);
    chk("idle_ready", 32'(REQ_READY), 32'd1);
  endtask

  task automatic load_small;
    for (int i = 0; i < 32; i++) begin
      tbl_s[i] = 8'hFF;
      tbl_c[i] = 4'h0;
      tbl_n[i] = 8'h00;
    end
    tbl_s[0] = 8'd0; tbl_c[0] = 4'd1; tbl_n[0] = 8'd1;
    tbl_s[1] = 8'd1; tbl_c[1] = 4'd2; tbl_n[1] = 8'd2;
    tbl_s[2] = 8'd0; tbl_c[2] = 4'd3; tbl_n[2] = 8'd5;
  endtask

  initial begin
    int cyc, ri;
    logic [7:0] rs;
    logic [3:0] rc;
    RST = 1'b1;
    REQ_VALID = 1'b0;
    REQ_STATE = '0;
    REQ_CHARA = '0;
    RSP_READY = 1'b0;
    load_small();
    #1;
    chk("rst_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_addr", 32'(ADDR_G), 32'd0);
    chk("rst_hit", 32'(RSP_HIT), 32'd0);
    chk("rst_next", 32'(RSP_NEXT_STATE), 32'd0);
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", 32'(REQ_READY), 32'd1);

    // small table: hit at row 2, end marker miss, root miss
    do_req(8'd0, 4'd3, 0, 1'b0);
    do_req(8'd2, 4'd7, 1, 1'b0);
    do_req(8'd0, 4'd9, 0, 1'b0);

    // backpressure with REQ_VALID held high, then back-to-back
    do_req(8'd1, 4'd2, 5, 1'b1);
    do_req(8'd0, 4'd1, 0, 1'b0);

    // full table, no marker, only row 31 matches
    for (int i = 0; i < 32; i++) begin
      tbl_s[i] = 8'd1;
      tbl_c[i] = 4'(i);
      tbl_n[i] = 8'(i + 8'h40);
    end
    tbl_s[31] = 8'd2; tbl_c[31] = 4'd5; tbl_n[31] = 8'h77;
    do_req(8'd2, 4'd5, 0, 1'b0);
    do_req(8'd3, 4'd5, 2, 1'b0);
    do_req(8'd0, 4'd5, 0, 1'b0);

    // reset in the middle of a scan
    load_small();
    @(negedge CLK);
    REQ_STATE = 8'd0;
    REQ_CHARA = 4'd3;
    REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_valid", 32'(RSP_VALID), 32'd0);
    chk("midrst_addr", 32'(ADDR_G), 32'd0);
    chk("midrst_ready", 32'(REQ_READY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    do_req(8'd0, 4'd1, 0, 1'b0);

    // random tables and requests against the scan model
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) begin
        tbl_s[i] = 8'($urandom_range(0, 3));
        tbl_c[i] = 4'($urandom_range(0, 15));
        tbl_n[i] = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 1) == 1)
        tbl_s[$urandom_range(4, 31)] = 8'hFF;
      for (int r = 0; r < 6; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          ri = $urandom_range(0, 31);
          rs = tbl_s[ri];
          rc = tbl_c[ri];
        end else begin
          rs = 8'($urandom_range(0, 4));
          rc = 4'($urandom_range(0, 15));
        end
        do_req(rs, rc, $urandom_range(0, 2), 1'b0);
      end
    end

    cyc = addr_over;
    chk("addr_max", 32'(cyc), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/goto_lookup_ctrl.md
Name: goto_lookup_ctrl

Overview:
- Sequences the goto-table RAM for the Aho-Corasick matcher.
- Accepts one (state, character) lookup request, scans table rows from address 0, and compares each registered RAM output against the request.
- Returns the goto next state, or a failure indication so the downstream failure-function stage can take over.
- Sits between the input-character stepper and the goto RAM; it is the only driver of the RAM address.

Parameters:
- DEPTH, 32, number of goto-table rows scanned (addresses 0..DEPTH-1).
- ADDR_W, 12, width of ADDR_G.
- STATE_W, 8, automaton state width.
- CHAR_W, 4, character code width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset: asynchronous, active-high.
- REQ_VALID  in  1  lookup request valid.
- REQ_READY  out  1  controller can accept a request.
- REQ_STATE  in  STATE_W  current automaton state.
- REQ_CHARA  in  CHAR_W  input character.
- ADDR_G  out  ADDR_W  goto RAM read address (registered).
- CURRENT_STATE_G  in  STATE_W  RAM row source-state field; valid one cycle after ADDR_G.
- CHARA  in  CHAR_W  RAM row character field.
- NEXT_STATE  in  STATE_W  RAM row destination-state field.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accepted by consumer.
- RSP_HIT  out  1  goto defined: 1 = RSP_NEXT_STATE is usable; 0 = failure path required.
- RSP_NEXT_STATE  out  STATE_W  resolved next state.

Behaviour:
- **Reset (RST=1, async):** FSM=IDLE; ADDR_G=0; RSP_VALID=0; RSP_HIT=0; RSP_NEXT_STATE=0; REQ_READY=0 while RST high, then 1. Latched request and read-pending flag are cleared.
- **Reset mid-operation:** any scan or pending response is discarded with no output glitch beyond the async clear.
- **FSM states:** IDLE, SCAN, RESP.
- **IDLE:**
  - REQ_READY=1.
  - On REQ_VALID&&REQ_READY (accept edge, cycle 0): latch REQ_STATE/REQ_CHARA, ADDR_G<=0, rd_pend<=1, go to SCAN.
- **SCAN:**
  - REQ_READY=0.
  - Each cycle, the RAM data presented corresponds to the address issued in the previous cycle (rd_addr = registered copy of ADDR_G).
  - ADDR_G increments by 1 per cycle while < DEPTH-1, then holds at DEPTH-1. It never exceeds DEPTH-1.
  - Extra reads issued before termination is detected are harmless and ignored.
- **Row evaluation, in priority order (only when rd_pend=1):**
  1. Match: CURRENT_STATE_G==latched state && CHARA==latched char. Set RSP_HIT=1, RSP_NEXT_STATE=NEXT_STATE; go to RESP.
  2. End marker: CURRENT_STATE_G==END_MARK (8'hFF). Terminate as a miss.
  3. Last row: rd_addr==DEPTH-1 with no match. Terminate as a miss.
- **Miss resolution:**
  - Latched state == ROOT_STATE (0): RSP_HIT=1, RSP_NEXT_STATE=0 (root self-loop).
  - Otherwise: RSP_HIT=0, RSP_NEXT_STATE=0.
- **Latency:**
  - Terminating row k: RSP_VALID rises exactly k+3 cycles after the accept edge.
  - Worst case for DEPTH=32 is 34 cycles.
- **RESP:**
  - RSP_VALID=1; RSP_HIT and RSP_NEXT_STATE are held stable until RSP_READY=1.
  - On RSP_VALID&&RSP_READY: RSP_VALID<=0, go to IDLE.
  - REQ_READY=0 throughout, so there is a minimum one-cycle gap between accepts.
- **Holding:** ADDR_G holds its last value outside SCAN. REQ_VALID outside IDLE is ignored, not queued.
- **Widths:** ADDR_W may exceed log2(DEPTH); upper bits are zero. All comparisons are exact-width equality.

Decomposition:
- **Shared package ac_pkg:**
  - STATE_W, CHAR_W.
  - ROOT_STATE = 0, END_MARK = 8'hFF.
  - FSM state enum (IDLE/SCAN/RESP).
  - Goto-row record type {state, chara, next}, reused by the failure-table controller.
- **Sub-module:** one natural sub-module, goto_row_match: combinational compare of a RAM row against the latched request, producing match and end-marker flags. The FSM, counter and response registers stay in goto_lookup_ctrl.

Test Plan:
- Table rows 0:(0,1,1), 1:(1,2,2), 2:(0,3,5), row 3 onward state=FF. Req (0,3) -> ADDR_G sequence 0,1,2,...; RSP_VALID at cycle 5; HIT=1; NEXT=5.
- Same table, req (2,7) -> end marker at row 3; RSP_VALID at cycle 6; HIT=0; NEXT=0.
- Same table, req (0,9) -> root miss; RSP_VALID at cycle 6; HIT=1; NEXT=0.
- Full 32-row table with no marker, req matching only row 31 -> RSP_VALID at cycle 34, HIT=1. Non-matching non-root req -> cycle 34, HIT=0. ADDR_G never exceeds 31.
- Backpressure: RSP_READY held low 5 cycles with REQ_VALID held high -> RSP outputs stable, REQ_READY=0. After RSP_READY=1, IDLE for one cycle, then the next request is accepted.
- RST pulsed at cycle 3 of a scan -> RSP_VALID=0 and ADDR_G=0 asynchronously. A following req (0,1) returns HIT=1, NEXT=1 at cycle 3.
